nibble_serial_adder_ctrl: RTL



---
 rtl/nibble_serial_adder_ctrl_if.sv | 25 ++
 rtl/nibble_serial_adder_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake/operand bundle for nibble_serial_adder_ctrl. The sub line exists only
// when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef NIBBLE_SERIAL_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit ripple slice, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_SUB_EN to add a sub input that turns the operation into a-b.
module RippleAdder_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = 4'b0;
    for (int i = 0; i < 4; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_partial;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_partial_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtraction is a + ~b + 1, so the carry-in is forced high.
  assign w_b_load   = bus.sub ? ~bus.b : bus.b;
  assign w_cin_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_load   = bus.b;
  assign w_cin_load = bus.cin;
`endif

  RippleAdder_4 u_slice (
    .i_a    (r_op_a[3:0]),
    .i_b    (r_op_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts the first one lands at bit 0.
  assign w_partial_next = {w_slice_sum, r_partial[WIDTH-1:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_partial <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op_a    <= bus.a;
            r_op_b    <= w_b_load;
            r_carry   <= w_cin_load;
            r_partial <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_op_a    <= {4'b0, r_op_a[WIDTH-1:4]};
          r_op_b    <= {4'b0, r_op_b[WIDTH-1:4]};
          r_partial <= w_partial_next;
          r_carry   <= w_slice_cout;
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_sum   <= w_partial_next;
            r_cout  <= w_slice_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule
